// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared ISA constants, fetch defaults and the fetch FSM state type.
package instruction_fetch_pkg;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int INSTR_WIDTH = 32;

   typedef enum logic {BOOT, RUN} fetch_state_e;

   function automatic logic [INSTR_WIDTH-1:0] byte_swap(input logic [INSTR_WIDTH-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction
endpackage

// File: rtl/instruction_fetch_fifo.sv
// instruction_fetch_fifo: DEPTH-entry in-order buffer of {pc, instr} with flush and occupancy count.
module instruction_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata,
   output logic [CW-1:0] count,
   output logic          empty
);
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = count_q == '0;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) mem_d[wr_ptr_q] = wdata;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: credit-limited sequential fetch with in-order buffering and redirect flush.
// Define FETCH_BYTE_SWAP_EN to byte-reverse returned words (big-endian memory model).
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   output logic                   mem_req,
   output logic [31:0]            mem_addr,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [31:0]            mem_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [31:0]            instr_pc,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target_pc, rdata;
   logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, count;
   logic [CW:0]   credit;
   logic [63:0]   head;
   logic          gnt, push, drop, pop, empty, unused_bits;

   assign target_pc   = {redirect_pc[31:2], 2'b00};
   assign unused_bits = ^redirect_pc[1:0];
   assign mem_addr    = fetch_pc_q;
   assign instr_valid = !empty;
   assign instr       = head[31:0];
   assign instr_pc    = head[63:32];

`ifdef FETCH_BYTE_SWAP_EN
   assign rdata = byte_swap(mem_rdata);
`else
   assign rdata = mem_rdata;
`endif

   // Outstanding counts every in-flight read, including ones already marked for discard.
   always_comb begin
      state_d       = RUN;
      credit        = {1'b0, outstanding_q} + {1'b0, count};
      mem_req       = state_q == RUN && credit < DEPTH_W;
      gnt           = mem_req && mem_gnt;
      push          = mem_rvalid && discard_q == '0 && !redirect_valid;
      drop          = mem_rvalid && discard_q != '0;
      pop           = instr_valid && instr_ready && !redirect_valid;
      outstanding_d = outstanding_q + CW'(gnt) - CW'(mem_rvalid);
      discard_d     = redirect_valid ? outstanding_d : discard_q - CW'(drop);
      fetch_pc_d    = redirect_valid ? target_pc : fetch_pc_q + (gnt ? 32'd4 : 32'd0);
      resp_pc_d     = redirect_valid ? target_pc : resp_pc_q + (push ? 32'd4 : 32'd0);
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end

   instruction_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (redirect_valid),
      .push    (push),
      .pop     (pop),
      .wdata   ({resp_pc_q, rdata}),
      .rdata   (head),
      .count   (count),
      .empty   (empty)
   );

   a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
      mem_rvalid |-> outstanding_q != '0)
      else $error("instruction_fetch: read response with no request outstanding");
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch sequencing, stalls, redirects, wrap and byte order.
module tb_instruction_fetch;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        mem_req, mem_gnt = 1'b0, mem_rvalid, instr_valid, instr_ready = 1'b0, redirect_valid = 1'b0;
   logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc = 32'h0;
   logic        w_req, w_rvalid, w_valid;
   logic [31:0] w_addr, w_instr, w_pc;
   logic        hold = 1'b0, rv = 1'b0;
   logic [31:0] rd = 32'h0;
   logic [31:0] pend[$], gq[$], xpc[$], xin[$], wq[$];
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   instruction_fetch u_dut (
      .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .reset_n(reset_n), .mem_req(w_req), .mem_addr(w_addr), .mem_gnt(1'b1),
      .mem_rvalid(w_rvalid), .mem_rdata(32'h0), .instr_valid(w_valid), .instr_ready(1'b1),
      .instr(w_instr), .instr_pc(w_pc), .redirect_valid(1'b0), .redirect_pc(32'h0)
   );

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a == 32'h10 ? 32'h1300_0093 : {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] w;
      w = mem_data(a);
`ifdef FETCH_BYTE_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   assign mem_rvalid = rv;
   assign mem_rdata  = rd;

   // In-order memory: answers one cycle after grant unless held back.
   always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rv <= 1'b0;
         pend.delete();
      end else begin
         if (mem_req && mem_gnt) pend.push_back(mem_addr);
         if (!hold && pend.size() > 0) begin
            rv <= 1'b1;
            rd <= mem_data(pend.pop_front());
         end else rv <= 1'b0;
      end

   always @(posedge clk or negedge reset_n)
      if (!reset_n) w_rvalid <= 1'b0;
      else w_rvalid <= w_req;

   always @(negedge clk)
      if (reset_n) begin
         if (mem_req && mem_gnt) gq.push_back(mem_addr);
         if (instr_valid && instr_ready && !redirect_valid) begin
            xpc.push_back(instr_pc);
            xin.push_back(instr);
         end
         if (w_req) wq.push_back(w_addr);
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(2);
      gq.delete(); xpc.delete(); xin.delete(); wq.delete();
      reset_n = 1'b1;
   endtask

   initial begin
      int cnt;
      #1;
      check("rst_req", 32'(mem_req), 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", instr_pc, 32'h0);

      // Streaming fetch, first instruction latency, wrap at top of address space
      mem_gnt = 1'b1; instr_ready = 1'b1;
      do_reset();
      cnt = 0;
      @(negedge clk);
      while (!instr_valid && cnt < 10) begin
         @(posedge clk); cnt++; @(negedge clk);
      end
      check("latency", 32'(cnt), 32'd3);
      cnt = 0;
      while (xpc.size() < 5 && cnt < 40) begin step(1); cnt++; end
      for (int i = 0; i < 4; i++) begin
         check("stream_addr", gq[i], 32'(i * 4));
         check("stream_pc", xpc[i], 32'(i * 4));
         check("stream_instr", xin[i], exp_word(32'(i * 4)));
      end
`ifdef FETCH_BYTE_SWAP_EN
      check("byte_order", xin[4], 32'h9300_0013);
`else
      check("byte_order", xin[4], 32'h1300_0093);
`endif
      check("wrap_a0", wq[0], 32'hFFFF_FFF8);
      check("wrap_a1", wq[1], 32'hFFFF_FFFC);
      check("wrap_a2", wq[2], 32'h0000_0000);

      // Decode stalled: credits exhausted after DEPTH grants
      instr_ready = 1'b0;
      do_reset();
      step(8);
      @(negedge clk);
      check("stall_grants", 32'(gq.size()), 32'd2);
      check("stall_req", 32'(mem_req), 32'h0);
      check("stall_addr", mem_addr, 32'h8);
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_pc", instr_pc, 32'h0);
      step(1);
      instr_ready = 1'b1;
      cnt = 0;
      while ((xpc.size() < 2 || gq.size() < 3) && cnt < 20) begin step(1); cnt++; end
      check("resume_pc0", xpc[0], 32'h0);
      check("resume_pc1", xpc[1], 32'h4);
      check("resume_addr", gq[2], 32'h8);

      // Redirect with two reads in flight
      hold = 1'b1;
      do_reset();
      step(6);
      check("inflight", 32'(gq.size()), 32'd2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1003; hold = 1'b0;
      gq.delete(); xpc.delete(); xin.delete();
      step(1);
      redirect_valid = 1'b0;
      @(negedge clk);
      check("redir_valid", 32'(instr_valid), 32'h0);
      check("redir_addr", mem_addr, 32'h1000);
      check("redir_req", 32'(mem_req), 32'h0);
      cnt = 0;
      while (xpc.size() < 1 && cnt < 20) begin step(1); cnt++; end
      check("redir_gaddr", gq[0], 32'h1000);
      check("redir_pc", xpc[0], 32'h1000);
      check("redir_instr", xin[0], exp_word(32'h1000));

      // Memory refusing grants
      mem_gnt = 1'b0;
      do_reset();
      step(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("nogrant_req", 32'(mem_req), 32'h1);
         check("nogrant_addr", mem_addr, 32'h0);
         check("nogrant_valid", 32'(instr_valid), 32'h0);
         step(1);
      end
      mem_gnt = 1'b1;
      cnt = 0;
      while (xpc.size() < 1 && cnt < 20) begin step(1); cnt++; end
      check("nogrant_pc", xpc[0], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
